// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed driver for a common-anode seven-segment display.
// Each digit gets a slot of SCAN_DIV cycles: BLANK_CYC cycles with every
// anode off (anti-ghosting gap), then the lit portion. All inputs are
// snapshotted once per frame so a displayed value never tears. Outputs are
// registered, active-low, and drive the board pins directly.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 2000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] HEX_IN,
  input  logic [7:0]  DISP_EN,
  input  logic [7:0]  DP_IN,
  input  logic        LAMP_TEST,
  output logic [7:0]  CAT,
  output logic [7:0]  AN,
  output logic        FRAME_STB
);

  localparam int unsigned     CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LIT  = CNT_W'(BLANK_CYC);

  typedef enum logic {
    PH_BLANK,
    PH_LIT
  } phase_e;

  // Slot position and digit index.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dig_q, dig_d;

  // Frame snapshot of the inputs; nibble d of hex_q is digit d.
  logic [7:0][3:0]  hex_q, hex_d;
  logic [7:0]       en_q, en_d;
  logic [7:0]       dp_q, dp_d;
  logic             lt_q, lt_d;

  // Registered pin drivers.
  logic [7:0]       an_q, an_d;
  logic [7:0]       cat_q, cat_d;
  logic             stb_q, stb_d;

  logic             snap;
  phase_e           phase;

  // Hex font, segments g..a, active-low.
  function automatic logic [6:0] font(input logic [3:0] nib);
    case (nib)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  // Next-state logic: slot/digit counting, snapshot capture and pin decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    dig_d = dig_q;
    hex_d = hex_q;
    en_d  = en_q;
    dp_d  = dp_q;
    lt_d  = lt_q;
    an_d  = 8'hFF;
    cat_d = 8'hFF;

    snap  = (cnt_q == '0) && (dig_q == '0);
    phase = (cnt_q < CNT_LIT) ? PH_BLANK : PH_LIT;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      dig_d = dig_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (snap) begin
      hex_d = HEX_IN;
      en_d  = DISP_EN;
      dp_d  = DP_IN;
      lt_d  = LAMP_TEST;
    end
    stb_d = snap;

    // Decode uses the shadow values held before this edge; the snapshot
    // edge itself always falls in a blank phase, so nothing stale shows.
    if (phase == PH_LIT) begin
      if (lt_q) begin
        an_d  = ~(8'h01 << dig_q);
        cat_d = 8'h00;
      end else begin
        an_d  = en_q[dig_q] ? ~(8'h01 << dig_q) : 8'hFF;
        cat_d = {~dp_q[dig_q], font(hex_q[dig_q])};
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values that existed before the edge.
    if (!RSTn) begin
      cnt_q <= '0;
      dig_q <= '0;
      hex_q <= '0;
      en_q  <= '0;
      dp_q  <= '0;
      lt_q  <= 1'b0;
      an_q  <= 8'hFF;
      cat_q <= 8'hFF;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      hex_q <= hex_d;
      en_q  <= en_d;
      dp_q  <= dp_d;
      lt_q  <= lt_d;
      an_q  <= an_d;
      cat_q <= cat_d;
      stb_q <= stb_d;
    end
  end

  assign AN        = an_q;
  assign CAT       = cat_q;
  assign FRAME_STB = stb_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=8, BLANK_CYC=2
// (64-cycle frame). Outputs are sampled on the falling clock edge.
module tb_seg7_scan_driver;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] HEX_IN;
  logic [7:0]  DISP_EN;
  logic [7:0]  DP_IN;
  logic        LAMP_TEST;
  logic [7:0]  CAT;
  logic [7:0]  AN;
  logic        FRAME_STB;

  int tests_run = 0;
  int fails     = 0;

  seg7_scan_driver #(
    .SCAN_DIV (8),
    .BLANK_CYC(2)
  ) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .HEX_IN   (HEX_IN),
    .DISP_EN  (DISP_EN),
    .DP_IN    (DP_IN),
    .LAMP_TEST(LAMP_TEST),
    .CAT      (CAT),
    .AN       (AN),
    .FRAME_STB(FRAME_STB)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walks ncyc cycles of a frame starting at its snapshot edge. Index 0 of
  // ean/ecat is digit 0. Optionally overwrites HEX_IN after cycle poke_at.
  task automatic check_frame(input string name,
                             input logic [7:0][7:0] ean,
                             input logic [7:0][7:0] ecat,
                             input int ncyc,
                             input int poke_at,
                             input logic [31:0] poke_val);
    for (int k = 0; k < ncyc; k++) begin
      int d;
      int c;
      logic [7:0] xa;
      logic [7:0] xc;
      @(posedge CLK);
      @(negedge CLK);
      d = k / 8;
      c = k % 8;
      if (c < 2) begin
        xa = 8'hFF;
        xc = 8'hFF;
      end else begin
        xa = ean[d];
        xc = ecat[d];
      end
      check($sformatf("%s AN k=%0d", name, k), AN, xa);
      check($sformatf("%s CAT k=%0d", name, k), CAT, xc);
      check($sformatf("%s STB k=%0d", name, k), FRAME_STB, (k == 0));
      check($sformatf("%s onehot k=%0d", name, k), ($countones(~AN) <= 1), 1);
      if (k == poke_at) HEX_IN = poke_val;
    end
  endtask

  localparam logic [7:0][7:0] AN_ALL   = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  localparam logic [7:0][7:0] CAT_SCAN = {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  localparam logic [7:0][7:0] AN_EN    = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFB, 8'hFF, 8'hFE};
  localparam logic [7:0][7:0] CAT_EN   = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h0E, 8'hC0, 8'h88};
  localparam logic [7:0][7:0] CAT_ZERO = {8{8'hC0}};
  localparam logic [7:0][7:0] CAT_F    = {8{8'h8E}};
  localparam logic [7:0][7:0] CAT_LAMP = {8{8'h00}};
  localparam logic [7:0][7:0] CAT_HI   = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    RSTn      = 1'b0;
    HEX_IN    = 32'h7654_3210;
    DISP_EN   = 8'hFF;
    DP_IN     = 8'h00;
    LAMP_TEST = 1'b0;

    // Reset held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("rst AN %0d", i), AN, 8'hFF);
      check($sformatf("rst CAT %0d", i), CAT, 8'hFF);
      check($sformatf("rst STB %0d", i), FRAME_STB, 1'b0);
    end
    RSTn = 1'b1;

    // Frame 0: plain scan of 76543210.
    check_frame("scan", AN_ALL, CAT_SCAN, 64, -1, 32'h0);

    // Frame 1: sparse enables with one decimal point.
    HEX_IN  = 32'h0000_0F0A;
    DISP_EN = 8'h05;
    DP_IN   = 8'h04;
    check_frame("en_dp", AN_EN, CAT_EN, 64, -1, 32'h0);

    // Frames 2-3: input changes mid-slot 3 must wait for the next frame.
    HEX_IN  = 32'h0;
    DISP_EN = 8'hFF;
    DP_IN   = 8'h00;
    check_frame("tear0", AN_ALL, CAT_ZERO, 64, 28, 32'hFFFF_FFFF);
    check_frame("tear1", AN_ALL, CAT_F, 64, -1, 32'h0);

    // Frame 4: lamp test lights every digit even with all enables off.
    LAMP_TEST = 1'b1;
    DISP_EN   = 8'h00;
    check_frame("lamp", AN_ALL, CAT_LAMP, 64, -1, 32'h0);

    // Frame 5: scan into slot 5 lit phase, then reset mid-frame.
    LAMP_TEST = 1'b0;
    DISP_EN   = 8'hFF;
    HEX_IN    = 32'h7654_3210;
    check_frame("pre_rst", AN_ALL, CAT_SCAN, 45, -1, 32'h0);
    check("pre_rst slot5 lit AN", AN, 8'hDF);
    RSTn   = 1'b0;
    HEX_IN = 32'hFEDC_BA98;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("mid_rst AN %0d", i), AN, 8'hFF);
      check($sformatf("mid_rst CAT %0d", i), CAT, 8'hFF);
      check($sformatf("mid_rst STB %0d", i), FRAME_STB, 1'b0);
    end
    RSTn = 1'b1;

    // Restart from digit 0 with a fresh snapshot, then one more frame to
    // confirm the strobe period.
    check_frame("restart", AN_ALL, CAT_HI, 64, -1, 32'h0);
    check_frame("restart2", AN_ALL, CAT_HI, 64, -1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
